// File: rtl/rept_pipe.sv
// rept_pipe: two-stage pre-round reduction between the normaliser and the rounder.
// Keeps the top K bits of the normalised significand (K chosen by the format),
// left-aligns them in a DB_KEEP-bit field and ORs every discarded bit into a
// sticky bit. Stage 1 registers kept bits and per-chunk partial ORs. Stage 2
// folds the partials and packs the rounder word. Both stages use valid/ready
// backpressure.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  input handshake (in_ready is combinational from out_ready)
//   fn, fmt, in_tag      significand, format (00 single, 01 double, 10 half,
//                        11 reserved), sideband tag
//   out_valid/out_ready  output handshake
//   f_out                kept bits followed by sticky, zero padded below
//   sticky_o, fmt_err    sticky copy, beat carried fmt=11
//   out_tag              sideband tag
//
// Optional feature (macro REPT_STATS_EN): adds stat_clr input and a saturating
// stat_cnt[15:0] output counting output transfers that carried sticky_o=1.
module rept_pipe #(
    parameter int unsigned IN_W    = 128,
    parameter int unsigned DB_KEEP = 54,
    parameter int unsigned SG_KEEP = 25,
    parameter int unsigned HF_KEEP = 12,
    parameter int unsigned CHUNK   = 32,
    parameter int unsigned TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    fn,
    input  logic [1:0]         fmt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DB_KEEP:0]   f_out,
    output logic               sticky_o,
    output logic               fmt_err,
`ifdef REPT_STATS_EN
    input  logic               stat_clr,
    output logic [15:0]        stat_cnt,
`endif
    output logic [TAG_W-1:0]   out_tag
);

    localparam int unsigned OUT_W  = DB_KEEP + 1;
    localparam int unsigned LOW_W  = IN_W - HF_KEEP;
    localparam int unsigned NCH    = (LOW_W + CHUNK - 1) / CHUNK;
    localparam int unsigned PAD_W  = NCH * CHUNK;
    localparam int unsigned STAT_W = 16;

    localparam logic [1:0] FMT_SG = 2'b00;
    localparam logic [1:0] FMT_DB = 2'b01;
    localparam logic [1:0] FMT_HF = 2'b10;
    localparam logic [1:0] FMT_RS = 2'b11;

    // Kept-bit masks over the left-aligned DB_KEEP field.
    localparam logic [DB_KEEP-1:0] KM_DB = {DB_KEEP{1'b1}};
    localparam logic [DB_KEEP-1:0] KM_SG = ~({DB_KEEP{1'b1}} >> SG_KEEP);
    localparam logic [DB_KEEP-1:0] KM_HF = ~({DB_KEEP{1'b1}} >> HF_KEEP);

    // Discard masks over the full significand: bits [IN_W-1-K:0].
    localparam logic [IN_W-1:0] DM_DB = {IN_W{1'b1}} >> DB_KEEP;
    localparam logic [IN_W-1:0] DM_SG = {IN_W{1'b1}} >> SG_KEEP;
    localparam logic [IN_W-1:0] DM_HF = {IN_W{1'b1}} >> HF_KEEP;

    // Parameter sanity: format widths must nest inside the input width.
    if (!((DB_KEEP > SG_KEEP) && (SG_KEEP > HF_KEEP) && (IN_W > DB_KEEP))) begin : g_bad_cfg
        $fatal(1, "rept_pipe: require DB_KEEP > SG_KEEP > HF_KEEP and IN_W > DB_KEEP");
    end

    // Pipeline control.
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s2_adv, s1_adv;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1 combinational reduction.
    logic [DB_KEEP-1:0] keep_mask_c;
    logic [IN_W-1:0]    disc_mask_c;
    logic               err_c;
    logic [IN_W-1:0]    masked_c;
    logic [PAD_W-1:0]   low_pad_c;
    logic [NCH-1:0]     part_c;
    logic [DB_KEEP-1:0] kept_c;

    always_comb begin
        keep_mask_c = KM_DB;
        disc_mask_c = DM_DB;
        err_c       = 1'b0;
        case (fmt)
            FMT_SG: begin
                keep_mask_c = KM_SG;
                disc_mask_c = DM_SG;
            end
            FMT_HF: begin
                keep_mask_c = KM_HF;
                disc_mask_c = DM_HF;
            end
            FMT_RS: err_c = 1'b1;
            default: ;
        endcase
    end

    // Top HF_KEEP bits are never discarded, so only the low LOW_W bits feed partials.
    assign masked_c  = fn & disc_mask_c;
    assign low_pad_c = PAD_W'(masked_c[LOW_W-1:0]);
    assign kept_c    = fn[IN_W-1 -: DB_KEEP] & keep_mask_c;

    for (genvar c = 0; c < NCH; c++) begin : g_part
        assign part_c[c] = |low_pad_c[c*CHUNK +: CHUNK];
    end

    // Stage 1 registers.
    logic [DB_KEEP-1:0] s1_kept_q, s1_kept_d;
    logic [NCH-1:0]     s1_part_q, s1_part_d;
    logic [1:0]         s1_fmt_q,  s1_fmt_d;
    logic               s1_err_q,  s1_err_d;
    logic [TAG_W-1:0]   s1_tag_q,  s1_tag_d;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_kept_d  = s1_kept_q;
        s1_part_d  = s1_part_q;
        s1_fmt_d   = s1_fmt_q;
        s1_err_d   = s1_err_q;
        s1_tag_d   = s1_tag_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_kept_d = kept_c;
                s1_part_d = part_c;
                s1_fmt_d  = fmt;
                s1_err_d  = err_c;
                s1_tag_d  = in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_kept_q  <= '0;
            s1_part_q  <= '0;
            s1_fmt_q   <= '0;
            s1_err_q   <= 1'b0;
            s1_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_kept_q  <= s1_kept_d;
            s1_part_q  <= s1_part_d;
            s1_fmt_q   <= s1_fmt_d;
            s1_err_q   <= s1_err_d;
            s1_tag_q   <= s1_tag_d;
        end
    end

    // Stage 2: fold partials and pack the rounder word; reserved format packs as double.
    logic             sticky_c;
    logic [OUT_W-1:0] pack_c;

    assign sticky_c = |s1_part_q;

    always_comb begin
        pack_c = {s1_kept_q, sticky_c};
        case (s1_fmt_q)
            FMT_SG:  pack_c = {s1_kept_q[DB_KEEP-1 -: SG_KEEP], sticky_c, {(DB_KEEP-SG_KEEP){1'b0}}};
            FMT_HF:  pack_c = {s1_kept_q[DB_KEEP-1 -: HF_KEEP], sticky_c, {(DB_KEEP-HF_KEEP){1'b0}}};
            default: pack_c = {s1_kept_q, sticky_c};
        endcase
    end

    logic [OUT_W-1:0] f_out_q,  f_out_d;
    logic             sticky_q, sticky_d;
    logic             err_q,    err_d;
    logic [TAG_W-1:0] tag_q,    tag_d;

    // Bubbles drop out_valid but leave the data outputs at their last value.
    always_comb begin
        out_valid_d = out_valid_q;
        f_out_d     = f_out_q;
        sticky_d    = sticky_q;
        err_d       = err_q;
        tag_d       = tag_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                f_out_d  = pack_c;
                sticky_d = sticky_c;
                err_d    = s1_err_q;
                tag_d    = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            f_out_q     <= '0;
            sticky_q    <= 1'b0;
            err_q       <= 1'b0;
            tag_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            f_out_q     <= f_out_d;
            sticky_q    <= sticky_d;
            err_q       <= err_d;
            tag_q       <= tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign f_out     = f_out_q;
    assign sticky_o  = sticky_q;
    assign fmt_err   = err_q;
    assign out_tag   = tag_q;

`ifdef REPT_STATS_EN
    // Saturating count of sticky output transfers; clear wins over increment.
    logic [STAT_W-1:0] stat_cnt_q, stat_cnt_d;

    always_comb begin
        stat_cnt_d = stat_cnt_q;
        if (stat_clr) begin
            stat_cnt_d = '0;
        end else if (out_valid_q && out_ready && sticky_q && (stat_cnt_q != {STAT_W{1'b1}})) begin
            stat_cnt_d = stat_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt_q <= '0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
        end
    end

    assign stat_cnt = stat_cnt_q;
`endif

endmodule
